// File: rtl/f_le_arb_pkg.sv
// Shared types and defaults for the f_less_or_equal request arbiter.
package f_le_arb_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned FLEN_DEFAULT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/f_le_arbiter_if.sv
// Requester-side bundle: compare request handshake plus held-result handshake per requester.
interface f_le_arbiter_if
  import f_le_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned FLEN = FLEN_DEFAULT
) ();

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][FLEN-1:0] req_a;
  logic [NREQ-1:0][FLEN-1:0] req_b;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic [NREQ-1:0]           rsp_res;
  logic [NREQ-1:0]           rsp_err;
  logic [NREQ-1:0]           rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_err
  );

endinterface

// File: rtl/f_le_arbiter_rr.sv
// Combinational round-robin picker: lowest eligible index at or above ptr, else lowest overall.
module rr_arbiter
  import f_le_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_o
);

  logic [IW-1:0] hi_idx;
  logic          hi_found;
  logic [IW-1:0] lo_idx;
  logic          lo_found;

  // Two ascending scans replace the modulo walk: the upper half (>= ptr) wins over the wrapped half.
  always_comb begin
    hi_idx   = '0;
    hi_found = 1'b0;
    lo_idx   = '0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (eligible_i[i]) begin
        if (!lo_found) begin
          lo_idx   = IW'(i);
          lo_found = 1'b1;
        end
        if (!hi_found && (i >= 32'(ptr_i))) begin
          hi_idx   = IW'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign winner_o = hi_found ? hi_idx : lo_idx;
  assign any_o    = lo_found;

endmodule

// File: rtl/f_le_arbiter.sv
// Time-shares one external f_less_or_equal comparator among NREQ requesters, one compare per cycle.
module f_le_arbiter
  import f_le_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned FLEN = FLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  f_le_arbiter_if.slave   req_if,
  output logic [FLEN-1:0] f_le_a,
  output logic [FLEN-1:0] f_le_b,
  input  logic            f_le_res,
  input  logic            f_le_err,
  output logic            busy
);

  localparam int unsigned IW = idx_w(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0] rsp_res_q, rsp_res_d;
  logic [NREQ-1:0] rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] gnt_onehot;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] arb_req;
  logic [IW-1:0]   winner;
  logic            any_win;

  always_comb begin
    gnt_onehot = '0;
    if (state_q == ST_CMP) begin
      gnt_onehot[gnt_q] = 1'b1;
    end
  end

  // A requester holding an unacknowledged result waits; the one under compare is excluded.
  assign eligible = req_if.req_valid & ~rsp_valid_q;
  assign arb_req  = eligible & ~gnt_onehot;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .eligible_i (arb_req),
    .ptr_i      (ptr_q),
    .winner_o   (winner),
    .any_o      (any_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE, ST_CMP: begin
        // Both states grant identically; CMP differs only by excluding the current grant.
        if (any_win) begin
          state_d = ST_CMP;
          gnt_d   = winner;
          ptr_d   = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q & ~req_if.rsp_ready;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == ST_CMP) begin
      rsp_valid_d[gnt_q] = 1'b1;
      rsp_res_d[gnt_q]   = f_le_res;
      rsp_err_d[gnt_q]   = f_le_err;
    end
  end

  assign busy             = (state_q == ST_CMP);
  assign f_le_a           = busy ? req_if.req_a[gnt_q] : '0;
  assign f_le_b           = busy ? req_if.req_b[gnt_q] : '0;
  assign req_if.req_ready = gnt_onehot;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_res   = rsp_res_q;
  assign req_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_f_le_arbiter.sv
// Directed bench for f_le_arbiter with a behavioural double-precision le comparator stub.
module tb_f_le_arbiter;

  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] NEG1  = 64'hBFF0000000000000;
  localparam logic [63:0] NEG2  = 64'hC000000000000000;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] PINF  = 64'h7FF0000000000000;
  localparam logic [63:0] NZERO = 64'h8000000000000000;

  logic        clk;
  logic        rst_n;
  logic [63:0] f_le_a;
  logic [63:0] f_le_b;
  logic        f_le_res;
  logic        f_le_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  f_le_arbiter_if #(.NREQ(4), .FLEN(64)) bus ();

  f_le_arbiter #(.NREQ(4), .FLEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (bus.slave),
    .f_le_a   (f_le_a),
    .f_le_b   (f_le_b),
    .f_le_res (f_le_res),
    .f_le_err (f_le_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {err, res}; any NaN operand raises err with res low.
  function automatic logic [1:0] fle_model(input logic [63:0] a, input logic [63:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != '0);
    b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != '0);
    if (a_nan || b_nan) return 2'b10;
    if ((a[62:0] == '0) && (b[62:0] == '0)) return 2'b01;
    if (a[63] != b[63]) return {1'b0, a[63]};
    if (!a[63]) return {1'b0, a[62:0] <= b[62:0]};
    return {1'b0, a[62:0] >= b[62:0]};
  endfunction

  always_comb {f_le_err, f_le_res} = fle_model(f_le_a, f_le_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  typedef struct {
    int unsigned req;
    logic [63:0] a;
    logic [63:0] b;
    logic        exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    int unsigned cnt0, cnt1, cnt3, ngr;
    logic seen;
    int unsigned gr[$];

    vecs[0] = '{0, ONE,   TWO,   1'b1, 1'b0};
    vecs[1] = '{1, TWO,   ONE,   1'b0, 1'b0};
    vecs[2] = '{2, QNAN,  ONE,   1'b0, 1'b1};
    vecs[3] = '{3, NEG1,  ONE,   1'b1, 1'b0};
    vecs[4] = '{0, 64'h0, NZERO, 1'b1, 1'b0};
    vecs[5] = '{1, NEG2,  NEG1,  1'b1, 1'b0};
    vecs[6] = '{2, ONE,   ONE,   1'b1, 1'b0};
    vecs[7] = '{3, PINF,  TWO,   1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    repeat (3) tick();
    check("rst busy",      64'(busy),          64'd0);
    check("rst req_ready", 64'(bus.req_ready), 64'd0);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst rsp_res",   64'(bus.rsp_res),   64'd0);
    check("rst rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst f_le_a",    f_le_a,             64'd0);
    rst_n = 1'b1;
    tick();

    // Isolated requests: ready one cycle after valid, result the cycle after.
    for (int v = 0; v < 8; v++) begin
      oh = '0;
      oh[vecs[v].req] = 1'b1;
      bus.req_a[vecs[v].req]     = vecs[v].a;
      bus.req_b[vecs[v].req]     = vecs[v].b;
      bus.req_valid[vecs[v].req] = 1'b1;
      tick();
      check($sformatf("v%0d req_ready", v), 64'(bus.req_ready), 64'(oh));
      check($sformatf("v%0d busy", v),      64'(busy),          64'd1);
      check($sformatf("v%0d f_le_a", v),    f_le_a,             vecs[v].a);
      check($sformatf("v%0d f_le_b", v),    f_le_b,             vecs[v].b);
      tick();
      check($sformatf("v%0d rsp_valid", v), 64'(bus.rsp_valid), 64'(oh));
      check($sformatf("v%0d rsp_res", v),   64'(bus.rsp_res[vecs[v].req]), 64'(vecs[v].exp_res));
      check($sformatf("v%0d rsp_err", v),   64'(bus.rsp_err[vecs[v].req]), 64'(vecs[v].exp_err));
      check($sformatf("v%0d idle busy", v), 64'(busy),          64'd0);
      check($sformatf("v%0d idle a", v),    f_le_a,             64'd0);
      bus.req_valid[vecs[v].req] = 1'b0;
      bus.rsp_ready[vecs[v].req] = 1'b1;
      tick();
      check($sformatf("v%0d rsp clear", v), 64'(bus.rsp_valid), 64'd0);
      bus.rsp_ready = '0;
    end

    // All four at once with ptr back at 0: grants 0,1,2,3 back to back.
    for (int unsigned r = 0; r < 4; r++) begin
      bus.req_a[r] = r[0] ? TWO : ONE;
      bus.req_b[r] = r[0] ? ONE : TWO;
    end
    bus.req_valid = 4'hF;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      oh = '0;
      oh[k] = 1'b1;
      check($sformatf("all4 grant%0d", k), 64'(bus.req_ready), 64'(oh));
      check($sformatf("all4 busy%0d", k),  64'(busy),          64'd1);
      bus.req_valid[k] = 1'b0;
    end
    tick();
    check("all4 end busy",  64'(busy),          64'd0);
    check("all4 rsp_valid", 64'(bus.rsp_valid), 64'hF);
    check("all4 rsp_res",   64'(bus.rsp_res),   64'h5);
    check("all4 rsp_err",   64'(bus.rsp_err),   64'h0);
    bus.rsp_ready = 4'hF;
    tick();
    check("all4 rsp clear", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = '0;

    // Requester 1 never acks: it must not be granted again until it does.
    cnt0 = 0; cnt1 = 0; cnt3 = 0;
    bus.req_valid = 4'b1011;
    bus.rsp_ready = 4'b1001;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.req_ready[0]) cnt0++;
      if (bus.req_ready[1]) cnt1++;
      if (bus.req_ready[3]) cnt3++;
    end
    check("hold grants1",   64'(cnt1),   64'd1);
    check("hold grants0",   64'(cnt0 >= 3), 64'd1);
    check("hold grants3",   64'(cnt3 >= 3), 64'd1);
    check("hold rsp_valid1", 64'(bus.rsp_valid[1]), 64'd1);
    bus.rsp_ready[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.req_ready[1]) seen = 1'b1;
    end
    check("ack regrant1", 64'(seen), 64'd1);
    bus.req_valid = '0;
    bus.rsp_ready = 4'hF;
    repeat (4) tick();
    check("drain busy",      64'(busy),          64'd0);
    check("drain rsp_valid", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = '0;

    // Reset while req3 is under compare: response dropped, outputs cleared immediately.
    bus.req_a[3]     = ONE;
    bus.req_b[3]     = TWO;
    bus.req_valid[3] = 1'b1;
    tick();
    check("rstmid ready3", 64'(bus.req_ready), 64'h8);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid busy",      64'(busy),          64'd0);
    check("rstmid req_ready", 64'(bus.req_ready), 64'd0);
    check("rstmid rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rstmid f_le_a",    f_le_a,             64'd0);
    bus.req_valid[3] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rstmid no rsp", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid[3] = 1'b1;
    tick();
    check("rerq ready3", 64'(bus.req_ready), 64'h8);
    tick();
    check("rerq rsp_valid", 64'(bus.rsp_valid), 64'h8);
    check("rerq rsp_res",   64'(bus.rsp_res[3]), 64'd1);
    bus.req_valid[3] = 1'b0;
    bus.rsp_ready[3] = 1'b1;
    tick();
    bus.rsp_ready = '0;

    // Fairness: 0 and 1 always requesting and always acking.
    bus.req_valid = 4'b0011;
    bus.rsp_ready = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      tick();
      for (int unsigned r = 0; r < 4; r++) begin
        if (bus.req_ready[r]) gr.push_back(r);
      end
    end
    ngr = gr.size();
    check("fair grant count", 64'(ngr), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gr.size()) check($sformatf("fair grant%0d", k), 64'(gr[k]), 64'(k % 2));
    end
    bus.req_valid = '0;
    bus.rsp_ready = 4'hF;
    repeat (4) tick();
    check("fair drain", 64'(bus.rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
